data_mem_responder: RTL and testbench

// - Responder end of the MEM-stage data-memory interface of the 5-stage MIPS pipeline.
// - Accepts mem_ren/mem_wen/mem_addr/mem_dout from the datapath and performs word accesses on a

---
 rtl/data_mem_responder_pkg.sv | 17 +
 rtl/data_mem_responder_ram.sv | 22 ++
 rtl/data_mem_responder.sv | 99 +++++++++
 tb/tb_data_mem_responder.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/data_mem_responder_pkg.sv
// Shared types and constants for the MEM-stage data-memory responder.
package data_mem_responder_pkg;

    typedef enum logic [1:0] {
        MEM_ST_IDLE = 2'd0,
        MEM_ST_BUSY = 2'd1,
        MEM_ST_DONE = 2'd2
    } mem_state_e;

    localparam int MEM_CNT_W  = 16;
    localparam int MEM_WAIT_W = 4;

    function automatic logic [MEM_CNT_W-1:0] sat_inc(input logic [MEM_CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/data_mem_responder_ram.sv
// Single-port word RAM with synchronous read and write; contents survive reset.
module data_ram #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata
);

    logic [31:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) mem[addr] <= wdata;
            else    rdata     <= mem[addr];
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// Responder for the pipeline's MEM-stage data port: wait-stated RAM access,
// illegal-request rejection and saturating debug counters.
//
// state | meaning
// IDLE  | waiting; legal request latched and stalled, illegal one faulted
// BUSY  | counting wait states, RAM accessed on terminal count
// DONE  | access complete, pipeline released for one cycle
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int                   ADDR_WIDTH    = 10,
    parameter int                   WAIT_STATES   = 1,
    parameter logic [MEM_CNT_W-1:0] RD_COUNT_INIT = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mem_ren,
    input  logic                 mem_wen,
    input  logic [31:0]          mem_addr,
    input  logic [31:0]          mem_dout,
    output logic [31:0]          mem_din,
    output logic                 mem_stall,
    output logic                 mem_fault,
    output logic [MEM_CNT_W-1:0] rd_count,
    output logic [MEM_CNT_W-1:0] wr_count,
    output logic [MEM_CNT_W-1:0] fault_count
);

    mem_state_e              state;
    logic [MEM_WAIT_W-1:0]   cnt;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [31:0]             wdata_q;
    logic                    wr_q;
    logic [31:0]             rdata_q;
    logic                    req;
    logic                    illegal;
    logic                    ram_en;

    assign req     = mem_ren | mem_wen;
    assign illegal = (mem_ren & mem_wen)
                   | (mem_addr[1:0] != 2'b00)
                   | (mem_addr[31:ADDR_WIDTH+2] != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= MEM_ST_IDLE;
            cnt         <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wr_q        <= 1'b0;
            rd_count    <= RD_COUNT_INIT;
            wr_count    <= '0;
            fault_count <= '0;
        end else begin
            case (state)
                MEM_ST_IDLE: begin
                    if (req && illegal) begin
                        fault_count <= sat_inc(fault_count);
                    end else if (req) begin
                        addr_q  <= mem_addr[ADDR_WIDTH+1:2];
                        wdata_q <= mem_dout;
                        wr_q    <= mem_wen;
                        cnt     <= MEM_WAIT_W'(WAIT_STATES);
                        state   <= MEM_ST_BUSY;
                    end
                end
                MEM_ST_BUSY: begin
                    if (cnt != '0) cnt   <= cnt - 1'b1;
                    else           state <= MEM_ST_DONE;
                end
                MEM_ST_DONE: begin
                    // Leave unconditionally: a flushed request still completed its access.
                    if (wr_q) wr_count <= sat_inc(wr_count);
                    else      rd_count <= sat_inc(rd_count);
                    state <= MEM_ST_IDLE;
                end
                default: state <= MEM_ST_IDLE;
            endcase
        end
    end

    assign ram_en = (state == MEM_ST_BUSY) && (cnt == '0);

    data_ram #(.ADDR_WIDTH(ADDR_WIDTH)) u_ram (
        .clk   (clk),
        .en    (ram_en),
        .we    (wr_q),
        .addr  (addr_q),
        .wdata (wdata_q),
        .rdata (rdata_q)
    );

    // Gated by rst so a request held across reset cannot raise stall or fault.
    assign mem_stall = !rst && ((state == MEM_ST_BUSY) ||
                                (state == MEM_ST_IDLE && req && !illegal));
    assign mem_fault = !rst && (state == MEM_ST_IDLE) && req && illegal;
    assign mem_din   = (state == MEM_ST_DONE && !wr_q) ? rdata_q : 32'h0;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed self-checking bench for data_mem_responder (ADDR_WIDTH=10, WAIT_STATES=1).
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_ren, mem_wen;
    logic [31:0] mem_addr, mem_dout;
    logic [31:0] mem_din;
    logic        mem_stall, mem_fault;
    logic [15:0] rd_count, wr_count, fault_count;

    logic [31:0] s_din;
    logic        s_stall, s_fault;
    logic [15:0] s_rd_count, s_wr_count, s_fault_count;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] din;
    int          stalls;

    always #5 clk = ~clk;

    data_mem_responder #(.ADDR_WIDTH(10), .WAIT_STATES(1)) dut (
        .clk(clk), .rst(rst), .mem_ren(mem_ren), .mem_wen(mem_wen),
        .mem_addr(mem_addr), .mem_dout(mem_dout), .mem_din(mem_din),
        .mem_stall(mem_stall), .mem_fault(mem_fault), .rd_count(rd_count),
        .wr_count(wr_count), .fault_count(fault_count)
    );

    data_mem_responder #(.ADDR_WIDTH(10), .WAIT_STATES(1), .RD_COUNT_INIT(16'hFFFE)) dut_sat (
        .clk(clk), .rst(rst), .mem_ren(mem_ren), .mem_wen(mem_wen),
        .mem_addr(mem_addr), .mem_dout(mem_dout), .mem_din(s_din),
        .mem_stall(s_stall), .mem_fault(s_fault), .rd_count(s_rd_count),
        .wr_count(s_wr_count), .fault_count(s_fault_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One access; optionally swaps addr/data once the request has been latched.
    task automatic access(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                          input logic swap, input logic [31:0] addr2, input logic [31:0] data2,
                          output logic [31:0] rdata, output int nstall);
        logic done;
        done   = 1'b0;
        nstall = 0;
        rdata  = 32'h0;
        @(negedge clk);
        mem_ren = !wr; mem_wen = wr; mem_addr = addr; mem_dout = data;
        for (int i = 0; i < 40 && !done; i++) begin
            #1;
            if (mem_stall) begin
                nstall++;
                @(negedge clk);
                if (swap) begin mem_addr = addr2; mem_dout = data2; end
            end else begin
                rdata = mem_din;
                done  = 1'b1;
            end
        end
        check("access_completes", {31'h0, done}, 32'h1);
    endtask

    task automatic rd(input logic [31:0] addr, output logic [31:0] rdata, output int nstall);
        access(1'b0, addr, 32'h0, 1'b0, 32'h0, 32'h0, rdata, nstall);
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data, output int nstall);
        logic [31:0] unused;
        access(1'b1, addr, data, 1'b0, 32'h0, 32'h0, unused, nstall);
    endtask

    task automatic idle;
        @(negedge clk);
        mem_ren = 1'b0; mem_wen = 1'b0;
        #1;
    endtask

    task automatic fault_req(input string tag, input logic ren, input logic wen, input logic [31:0] addr);
        @(negedge clk);
        mem_ren = ren; mem_wen = wen; mem_addr = addr; mem_dout = 32'h12345678;
        #1;
        check({tag, "_fault"}, {31'h0, mem_fault}, 32'h1);
        check({tag, "_stall"}, {31'h0, mem_stall}, 32'h0);
        idle();
        check({tag, "_fault_clr"}, {31'h0, mem_fault}, 32'h0);
    endtask

    task automatic pulse_reset;
        @(negedge clk);
        mem_ren = 1'b0; mem_wen = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; mem_ren = 1'b0; mem_wen = 1'b0; mem_addr = 32'h0; mem_dout = 32'h0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_din", mem_din, 32'h0);
        check("rst_stall", {31'h0, mem_stall}, 32'h0);
        check("rst_fault", {31'h0, mem_fault}, 32'h0);
        check("rst_rd_count", {16'h0, rd_count}, 32'h0);
        check("rst_wr_count", {16'h0, wr_count}, 32'h0);
        check("rst_fault_count", {16'h0, fault_count}, 32'h0);
        check("sat_rst", {16'h0, s_rd_count}, 32'h0000FFFE);
        rst = 1'b0;

        // Preload through the port, then reset: RAM content must survive.
        wr(32'h10, 32'hCAFEF00D, stalls);
        pulse_reset();
        #1;
        check("wr_count_after_rst", {16'h0, wr_count}, 32'h0);

        rd(32'h10, din, stalls);
        check("rd10_stalls", stalls, 3);
        check("rd10_data", din, 32'hCAFEF00D);
        idle();
        check("rd_count_1", {16'h0, rd_count}, 32'h1);
        check("sat_one_read", {16'h0, s_rd_count}, 32'h0000FFFF);

        // Back-to-back write then read of the same word.
        wr(32'h20, 32'hDEADBEEF, stalls);
        check("wr20_stalls", stalls, 3);
        check("wr_done_din", mem_din, 32'h0);
        rd(32'h20, din, stalls);
        check("rd20_stalls", stalls, 3);
        check("rd20_data", din, 32'hDEADBEEF);
        idle();
        check("wr_count_b2b", {16'h0, wr_count}, 32'h1);
        check("rd_count_b2b", {16'h0, rd_count}, 32'h2);

        fault_req("misaligned", 1'b1, 1'b0, 32'h13);
        fault_req("out_of_range", 1'b1, 1'b0, 32'h0001_0000);
        fault_req("ren_wen", 1'b1, 1'b1, 32'h20);
        check("fault_count", {16'h0, fault_count}, 32'h3);
        check("rd_count_no_fault", {16'h0, rd_count}, 32'h2);
        rd(32'h10, din, stalls);
        check("after_fault_10", din, 32'hCAFEF00D);
        rd(32'h20, din, stalls);
        check("after_fault_20", din, 32'hDEADBEEF);

        // Inputs changed during BUSY must be ignored.
        wr(32'h34, 32'h33333333, stalls);
        access(1'b1, 32'h30, 32'h11111111, 1'b1, 32'h34, 32'h22222222, din, stalls);
        check("swap_stalls", stalls, 3);
        rd(32'h30, din, stalls);
        check("swap_latched", din, 32'h11111111);
        rd(32'h34, din, stalls);
        check("swap_ignored", din, 32'h33333333);
        idle();
        check("wr_count_swap", {16'h0, wr_count}, 32'h3);
        check("rd_count_swap", {16'h0, rd_count}, 32'h6);

        // Reset in BUSY with cnt=1: write must not commit.
        wr(32'h40, 32'hAAAA5555, stalls);
        @(negedge clk);
        mem_ren = 1'b0; mem_wen = 1'b1; mem_addr = 32'h40; mem_dout = 32'h0BADF00D;
        @(negedge clk);
        #1;
        check("busy_stall_before_rst", {31'h0, mem_stall}, 32'h1);
        rst = 1'b1;
        #1;
        check("abort_din", mem_din, 32'h0);
        check("abort_stall", {31'h0, mem_stall}, 32'h0);
        check("abort_fault", {31'h0, mem_fault}, 32'h0);
        check("abort_rd_count", {16'h0, rd_count}, 32'h0);
        check("abort_wr_count", {16'h0, wr_count}, 32'h0);
        check("abort_fault_count", {16'h0, fault_count}, 32'h0);
        check("sat_abort", {16'h0, s_rd_count}, 32'h0000FFFE);
        @(negedge clk);
        mem_ren = 1'b0; mem_wen = 1'b0;
        rst = 1'b0;
        rd(32'h40, din, stalls);
        check("abort_rd_stalls", stalls, 3);
        check("abort_word_kept", din, 32'hAAAA5555);
        rd(32'h10, din, stalls);
        rd(32'h20, din, stalls);
        check("final_rd20", din, 32'hDEADBEEF);
        idle();
        check("rd_count_final", {16'h0, rd_count}, 32'h3);
        check("sat_final", {16'h0, s_rd_count}, 32'h0000FFFF);
        check("wr_count_final", {16'h0, wr_count}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
